// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: fetches from PC_o, decodes control flow back into the PC,
// issues plain instructions downstream, and bounds memory latency with a watchdog.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_CLR   | command the PC to clear (sel=11) for one cycle
// S_FETCH | request word at PC_o, wait for ack or watchdog expiry
// S_EXEC  | act on ir: issue OP, jump, conditional jump, or halt
// S_HALT  | idle with halted=1 until restart
module fetch_sequencer #(
    parameter int N  = 4,
    parameter int W  = 8,
    parameter int TO = 15
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] PC_o,
    output logic [1:0]   sel,
    output logic [N-1:0] jumpDir,
    output logic         mem_req,
    output logic [N-1:0] mem_addr,
    input  logic         mem_ack,
    input  logic [W-1:0] mem_data,
    input  logic         zero_flag,
    output logic         out_valid,
    output logic [W-1:0] out_instr,
    input  logic         out_ready,
    input  logic         restart,
    output logic         halted,
    output logic         fetch_err
);

    typedef enum logic [1:0] {
        S_CLR   = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    localparam logic [1:0] OPC_OP   = 2'b00;
    localparam logic [1:0] OPC_JMP  = 2'b01;
    localparam logic [1:0] OPC_JZ   = 2'b10;
    localparam logic [1:0] OPC_HALT = 2'b11;

    localparam logic [1:0] SEL_HOLD = 2'b00;
    localparam logic [1:0] SEL_INC  = 2'b01;
    localparam logic [1:0] SEL_LOAD = 2'b10;
    localparam logic [1:0] SEL_CLR  = 2'b11;

    // Expiry is checked one count early so the error fires after exactly TO ack-less cycles.
    localparam logic [7:0] WDOG_LAST = 8'(TO - 1);

    state_t       state;
    state_t       state_nxt;
    logic [W-1:0] ir;
    logic [W-1:0] ir_nxt;
    logic [7:0]   wdog;
    logic [7:0]   wdog_nxt;
    logic         fetch_err_nxt;
    logic [1:0]   opcode;
    logic [N-1:0] target;

    assign opcode = ir[W-1:W-2];
    assign target = ir[N-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_CLR;
            ir        <= '0;
            wdog      <= '0;
            fetch_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            ir        <= ir_nxt;
            wdog      <= wdog_nxt;
            fetch_err <= fetch_err_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        ir_nxt        = ir;
        wdog_nxt      = wdog;
        fetch_err_nxt = fetch_err;
        sel           = SEL_HOLD;
        jumpDir       = '0;
        mem_req       = 1'b0;
        mem_addr      = '0;
        out_valid     = 1'b0;
        out_instr     = '0;
        halted        = 1'b0;

        case (state)
            S_CLR: begin
                sel       = SEL_CLR;
                wdog_nxt  = '0;
                state_nxt = S_FETCH;
            end
            S_FETCH: begin
                mem_req  = 1'b1;
                mem_addr = PC_o;
                // Ack takes priority over a watchdog expiry in the same cycle.
                if (mem_ack) begin
                    ir_nxt    = mem_data;
                    wdog_nxt  = '0;
                    state_nxt = S_EXEC;
                end else if (wdog == WDOG_LAST) begin
                    fetch_err_nxt = 1'b1;
                    wdog_nxt      = '0;
                    state_nxt     = S_HALT;
                end else begin
                    wdog_nxt = wdog + 8'd1;
                end
            end
            S_EXEC: begin
                case (opcode)
                    OPC_OP: begin
                        out_valid = 1'b1;
                        out_instr = ir;
                        if (out_ready) begin
                            sel       = SEL_INC;
                            state_nxt = S_FETCH;
                        end
                    end
                    OPC_JMP: begin
                        sel       = SEL_LOAD;
                        jumpDir   = target;
                        state_nxt = S_FETCH;
                    end
                    OPC_JZ: begin
                        if (zero_flag) begin
                            sel     = SEL_LOAD;
                            jumpDir = target;
                        end else begin
                            sel = SEL_INC;
                        end
                        state_nxt = S_FETCH;
                    end
                    OPC_HALT: begin
                        state_nxt = S_HALT;
                    end
                    default: state_nxt = S_HALT;
                endcase
            end
            S_HALT: begin
                halted = 1'b1;
                if (restart) state_nxt = S_CLR;
            end
            default: state_nxt = S_CLR;
        endcase
    end

endmodule
